// File: rtl/tech_ram_pkg.sv
// Shared types and helpers for the two-port technology RAM wrapper.
// expandMask handles words up to MAX_BYTES*8 bits; callers size-cast in and out.
package tech_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ramState_e;

  localparam int MAX_BYTES = 128;

  function automatic logic [MAX_BYTES*8-1:0] expandMask(input logic [MAX_BYTES-1:0] bw);
    logic [MAX_BYTES*8-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      mask[i*8 +: 8] = {8{bw[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/tech_ram_2p_array.sv
// Plain 1R1W storage with byte write enables and combinational read, no reset.
// Backend flows define BACKEND and supply a macro wrapper under this module name instead.
`ifndef BACKEND
module tech_ram_2p_array #(
  parameter int BIT_WIDTH  = 128,
  parameter int WORD_DEPTH = 64,
  localparam int AW = $clog2(WORD_DEPTH),
  localparam int NB = BIT_WIDTH / 8
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [NB-1:0]        wr_bw_i,
  input  logic [BIT_WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [BIT_WIDTH-1:0] rd_dat_o
);

  logic [BIT_WIDTH-1:0] mem_q [WORD_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_bw_i[i]) begin
          mem_q[wr_addr_i][i*8 +: 8] <= wr_dat_i[i*8 +: 8];
        end
      end
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule
`endif

// File: rtl/tech_ram_2p.sv
// Two-port RAM wrapper: zero-fill FSM, write-first forwarding, range checking
// and a 1- or 2-stage read pipeline around the raw storage array.
module tech_ram_2p
  import tech_ram_pkg::*;
#(
  parameter int BIT_WIDTH  = 128,
  parameter int WORD_DEPTH = 64,
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1,
  localparam int AW = $clog2(WORD_DEPTH),
  localparam int NB = BIT_WIDTH / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [NB-1:0]        wr_bw_i,
  input  logic [BIT_WIDTH-1:0] wr_dat_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [BIT_WIDTH-1:0] rd_dat_o,
  output logic                 rd_valid_o,
  output logic                 init_done_o,
  output logic                 addr_err_o
);

  ramState_e            state_q;
  logic [AW-1:0]        fillCnt_q;
  logic                 initDone_q;
  logic                 addrErr_q;
  logic                 rdValid1_q;
  logic [BIT_WIDTH-1:0] rdDat1_q;
  logic [BIT_WIDTH-1:0] rdDat_d;

  logic                 ready;
  logic                 wrInRange;
  logic                 rdInRange;
  logic                 wrAccept;
  logic                 rdAccept;
  logic                 collide;
  logic [BIT_WIDTH-1:0] fwdMask;

  logic                 arrWe;
  logic [AW-1:0]        arrWaddr;
  logic [NB-1:0]        arrBw;
  logic [BIT_WIDTH-1:0] arrWdat;
  logic [BIT_WIDTH-1:0] arrRdat;

  assign ready     = (state_q == ST_READY);
  assign wrInRange = int'(wr_addr_i) < WORD_DEPTH;
  assign rdInRange = int'(rd_addr_i) < WORD_DEPTH;
  assign wrAccept  = ready && wr_en_i && wrInRange;
  assign rdAccept  = ready && rd_en_i;
  assign collide   = wrAccept && rdAccept && (rd_addr_i == wr_addr_i);

  // The fill owns the write port while in INIT; user requests only reach it in READY.
  always_comb begin
    arrWe    = 1'b0;
    arrWaddr = wr_addr_i;
    arrBw    = wr_bw_i;
    arrWdat  = wr_dat_i;
    if (!ready) begin
      if (INIT_ZERO != 0) begin
        arrWe    = 1'b1;
        arrWaddr = fillCnt_q;
        arrBw    = '1;
        arrWdat  = '0;
      end
    end else begin
      arrWe = wrAccept;
    end
  end

  tech_ram_2p_array #(
    .BIT_WIDTH (BIT_WIDTH),
    .WORD_DEPTH(WORD_DEPTH)
  ) u_array (
    .clk_i    (clk_i),
    .wr_en_i  (arrWe),
    .wr_addr_i(arrWaddr),
    .wr_bw_i  (arrBw),
    .wr_dat_i (arrWdat),
    .rd_addr_i(rd_addr_i),
    .rd_dat_o (arrRdat)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_INIT;
      fillCnt_q  <= '0;
      initDone_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if ((INIT_ZERO == 0) || (fillCnt_q == AW'(WORD_DEPTH - 1))) begin
            state_q    <= ST_READY;
            initDone_q <= 1'b1;
          end else begin
            fillCnt_q <= fillCnt_q + AW'(1);
          end
        end
        ST_READY: begin
          initDone_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_INIT;
          initDone_q <= 1'b0;
        end
      endcase
    end
  end

  // Write-first: bytes written this cycle override the array's stale word.
  assign fwdMask = collide ? BIT_WIDTH'(expandMask(MAX_BYTES'(wr_bw_i))) : '0;
  assign rdDat_d = rdInRange ? ((arrRdat & ~fwdMask) | (wr_dat_i & fwdMask)) : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdValid1_q <= 1'b0;
      rdDat1_q   <= '0;
      addrErr_q  <= 1'b0;
    end else begin
      rdValid1_q <= rdAccept;
      if (rdAccept) begin
        rdDat1_q <= rdDat_d;
      end
      if (ready && ((wr_en_i && !wrInRange) || (rd_en_i && !rdInRange))) begin
        addrErr_q <= 1'b1;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic                 rdValid2_q;
      logic [BIT_WIDTH-1:0] rdDat2_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          rdValid2_q <= 1'b0;
          rdDat2_q   <= '0;
        end else begin
          rdValid2_q <= rdValid1_q;
          if (rdValid1_q) begin
            rdDat2_q <= rdDat1_q;
          end
        end
      end

      assign rd_valid_o = rdValid2_q;
      assign rd_dat_o   = rdDat2_q;
    end else begin : g_noOutReg
      assign rd_valid_o = rdValid1_q;
      assign rd_dat_o   = rdDat1_q;
    end
  endgenerate

  assign init_done_o = initDone_q;
  assign addr_err_o  = addrErr_q;

endmodule

// File: doc/tech_ram_2p.md
TECH_RAM_2P -- requirements
Module: tech_ram_2p

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 128, meaning word width in bits (multiple of 8, >= 8).
REQ-002 SHALL have parameter WORD_DEPTH, default 64, meaning number of words (>= 2, need not be a power of two).
REQ-003 SHALL have parameter OUT_REG, default 0, meaning read latency of 1 cycle (0) or 2 cycles (1).
REQ-004 SHALL have parameter INIT_ZERO, default 1, meaning zero-fill the array after reset (1) or skip fill (0).
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-006 clk_i  input  1  sole clock, rising edge.
REQ-007 rst_n_i  input  1  asynchronous active-low reset.
REQ-008 wr_en_i  input  1  write request, active high.
REQ-009 wr_addr_i  input  $clog2(WORD_DEPTH)  write address.
REQ-010 wr_bw_i  input  BIT_WIDTH/8  byte write enables; bit i covers bits i*8+7..i*8.
REQ-011 wr_dat_i  input  BIT_WIDTH  write data.
REQ-012 rd_en_i  input  1  read request, active high.
REQ-013 rd_addr_i  input  $clog2(WORD_DEPTH)  read address.
REQ-014 rd_dat_o  output  BIT_WIDTH  read data.
REQ-015 rd_valid_o  output  1  one-cycle pulse marking rd_dat_o as new.
REQ-016 init_done_o  output  1  high once the array is accepting requests.
REQ-017 addr_err_o  output  1  sticky flag set by any accepted request with an address >= WORD_DEPTH.

Function
REQ-018 SHALL implement an FSM with states INIT and READY; the FSM enters INIT on reset.
REQ-019 In INIT with INIT_ZERO=1, the block SHALL write all-zero data to one address per cycle, from 0 to WORD_DEPTH-1, then enter READY; the fill takes exactly WORD_DEPTH cycles.
REQ-020 With INIT_ZERO=0, the FSM SHALL move from INIT to READY on the first clock after reset release.
REQ-021 init_done_o SHALL be 0 in INIT and 1 in READY.
REQ-022 In INIT, wr_en_i and rd_en_i SHALL be ignored: no write, no rd_valid_o, no addr_err_o update.
REQ-023 In READY, a write SHALL update only the bytes whose wr_bw_i bit is 1, with the new value visible to a read in the next cycle.
REQ-024 A write with wr_bw_i equal to 0 SHALL leave the word unchanged.
REQ-025 In READY, rd_en_i SHALL produce rd_valid_o and the read word exactly 1 cycle later when OUT_REG=0, or 2 cycles later when OUT_REG=1.
REQ-026 Back-to-back reads SHALL be accepted every cycle.
REQ-027 A read and a write to the same address in the same cycle SHALL be write-first: enabled bytes come from wr_dat_i, the other bytes keep their old value.
REQ-028 rd_dat_o SHALL hold its last value when rd_valid_o is 0.
REQ-029 An out-of-range write SHALL be dropped.
REQ-030 An out-of-range read SHALL return all-zero data with a normal rd_valid_o pulse.
REQ-031 Either kind of out-of-range request SHALL set addr_err_o, which clears only on reset.
REQ-032 Read data SHALL never be X-randomised; all outputs SHALL be deterministic.

Reset
REQ-033 On assertion of rst_n_i, the block SHALL reset asynchronously to: FSM=INIT, fill counter=0, rd_dat_o=0, rd_valid_o=0, init_done_o=0, addr_err_o=0, and any in-flight read pipeline flushed.
REQ-034 A reset during INIT or READY SHALL restart the fill from address 0.
REQ-035 The array contents SHALL have no reset.

Structure
REQ-036 Package tech_ram_pkg SHALL hold the FSM state enum and a byte-mask expansion function.
REQ-037 The storage SHALL be a sub-module tech_ram_2p_array, a plain 1R1W clocked array with byte-write and no reset.
REQ-038 tech_ram_2p_array SHALL be the only part replaced by a technology macro when BACKEND is defined.
REQ-039 The FSM, forwarding, range check and output pipeline SHALL live in tech_ram_2p.

Verification
REQ-040 Fill: BIT_WIDTH=32, WORD_DEPTH=8, INIT_ZERO=1; release reset -> init_done_o rises after exactly 8 cycles; reads of addresses 0..7 return 0x00000000.
REQ-041 Byte write: write 0xAABBCCDD to addr 3 with bw=4'b1111, then 0x11223344 with bw=4'b0101; read addr 3 -> 0xAA22CC44.
REQ-042 Collision: word 5 = 0x0; same cycle write 0xFFFFFFFF bw=4'b0011 and read addr 5 -> rd_dat_o=0x0000FFFF.
REQ-043 Latency: OUT_REG=1, reads on 4 consecutive cycles -> 4 consecutive rd_valid_o pulses starting 2 cycles after the first read, in order.
REQ-044 Range: WORD_DEPTH=6, write to addr 7 then read addr 7 -> rd_dat_o=0, addr_err_o=1 until reset.
REQ-045 Mid-init reset: assert rst_n_i at fill count 4, release -> all outputs 0, init_done_o rises WORD_DEPTH cycles after release.
